// File: rtl/serial_debug_mc.sv
// Daisy-chain serial debug node: receives frames on rx_clk/rx_data, decodes them against the
// enumerated node address, services identity/status/channel accesses and forwards on tx_clk/tx_data.
module serial_debug_mc #(
   parameter int unsigned DATA_W      = 128,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [7:0]               i_prescaler,
   input  logic                     i_rx_clk,
   input  logic                     i_rx_data,
   output logic                     o_tx_clk,
   output logic                     o_tx_data,
   input  logic [DATA_W-1:0]        i_identity,
   input  logic [NUM_CH*DATA_W-1:0] i_debug_outgoing_data,
   output logic [NUM_CH*DATA_W-1:0] o_debug_incoming_data,
   output logic [NUM_CH-1:0]        o_debug_incoming_tgl,
   output logic [14:0]              o_node_addr,
   output logic                     o_enumerated
);

   localparam int unsigned FRAME_W = DATA_W + 24;
   localparam int unsigned CNT_W   = $clog2(FRAME_W);
   localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

   logic [2:0]               r_rx_clk_sync;
   logic [1:0]               r_rx_data_sync;
   logic [FRAME_W-1:0]       r_rx_shift;
   logic [CNT_W-1:0]         r_rx_cnt;
   logic [TO_W-1:0]          r_idle_cnt;
   logic                     r_rx_done;
   logic [7:0]               r_timeout_cnt;
   logic [7:0]               r_drop_cnt;
   logic [FRAME_W-1:0]       r_hold;
   logic                     r_hold_vld;
   logic [14:0]              r_node_addr;
   logic                     r_enumerated;
   logic [NUM_CH*DATA_W-1:0] r_ch_data;
   logic [NUM_CH-1:0]        r_ch_tgl;

   state_t                   r_state, w_state_nxt;
   logic [7:0]               r_phase, w_phase_nxt;
   logic [7:0]               r_psc, w_psc_nxt;
   logic [FRAME_W-1:0]       r_tx_sh, w_tx_sh_nxt;
   logic [CNT_W-1:0]         r_tx_bit, w_tx_bit_nxt;
   logic                     r_tx_clk, w_tx_clk_nxt;
   logic                     r_tx_dat, w_tx_dat_nxt;
   logic                     w_hold_take;

   logic                     w_rx_rise;
   logic [14:0]              w_addr;
   logic                     w_rw;
   logic [7:0]               w_cmd;
   logic [DATA_W-1:0]        w_payload;
   logic                     w_bcast;
   logic                     w_hit;
   logic [FRAME_W-1:0]       w_fwd;
   logic [NUM_CH-1:0]        w_wr_ch;
   logic                     w_accept;
   logic                     w_drop;

   assign w_rx_rise = r_rx_clk_sync[1] & ~r_rx_clk_sync[2];

   // Receive: synchronise, shift on rising rx_clk, discard stalled partial frames
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_clk_sync  <= '1;
         r_rx_data_sync <= '0;
         r_rx_shift     <= '0;
         r_rx_cnt       <= '0;
         r_idle_cnt     <= '0;
         r_rx_done      <= 1'b0;
         r_timeout_cnt  <= '0;
      end else begin
         r_rx_clk_sync  <= {r_rx_clk_sync[1:0], i_rx_clk};
         r_rx_data_sync <= {r_rx_data_sync[0], i_rx_data};
         r_rx_done      <= 1'b0;
         if (w_rx_rise) begin
            r_rx_shift <= {r_rx_shift[FRAME_W-2:0], r_rx_data_sync[1]};
            r_idle_cnt <= '0;
            if (r_rx_cnt == CNT_W'(FRAME_W - 1)) begin
               r_rx_cnt  <= '0;
               r_rx_done <= 1'b1;
            end else begin
               r_rx_cnt <= r_rx_cnt + CNT_W'(1);
            end
         end else if (r_rx_cnt != '0) begin
            if (r_idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
               r_rx_cnt   <= '0;
               r_idle_cnt <= '0;
               if (r_timeout_cnt != 8'hFF) r_timeout_cnt <= r_timeout_cnt + 8'd1;
            end else begin
               r_idle_cnt <= r_idle_cnt + TO_W'(1);
            end
         end
      end
   end

   assign w_rw      = r_rx_shift[0];
   assign w_addr    = r_rx_shift[15:1];
   assign w_cmd     = r_rx_shift[23:16];
   assign w_payload = r_rx_shift[FRAME_W-1:24];
   assign w_accept  = r_rx_done & ~r_hold_vld;
   assign w_drop    = r_rx_done & r_hold_vld;

   // Decode: build the forwarded frame and select any channel write
   always_comb begin
      w_bcast = (w_addr == 15'h7FFF);
      w_hit   = !w_bcast && r_enumerated && (w_addr == r_node_addr);
      w_fwd   = r_rx_shift;
      w_wr_ch = '0;
      if (w_bcast) begin
         w_fwd[24 +: 15] = w_payload[14:0] + 15'd1;
      end else if (w_hit && !w_rw) begin
         if (w_cmd == 8'h00) w_fwd[FRAME_W-1:24] = i_identity;
         if (w_cmd == 8'hFE) w_fwd[FRAME_W-1:24] = DATA_W'({r_drop_cnt, r_timeout_cnt});
         for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (w_cmd == 8'(n + 1)) w_fwd[FRAME_W-1:24] = i_debug_outgoing_data[n*DATA_W +: DATA_W];
         end
      end else if (w_hit && w_rw) begin
         for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (w_cmd == 8'(n + 1)) w_wr_ch[n] = 1'b1;
         end
      end
   end

   // Side effects and holding register; a dropped frame has no side effects
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold       <= '0;
         r_hold_vld   <= 1'b0;
         r_drop_cnt   <= '0;
         r_node_addr  <= '0;
         r_enumerated <= 1'b0;
         r_ch_data    <= '0;
         r_ch_tgl     <= '0;
      end else begin
         if (w_hold_take) r_hold_vld <= 1'b0;
         if (w_accept) begin
            r_hold     <= w_fwd;
            r_hold_vld <= 1'b1;
            if (w_bcast) begin
               r_node_addr  <= w_payload[14:0];
               r_enumerated <= 1'b1;
            end
            for (int unsigned n = 0; n < NUM_CH; n++) begin
               if (w_wr_ch[n]) begin
                  r_ch_data[n*DATA_W +: DATA_W] <= w_payload;
                  r_ch_tgl[n]                   <= ~r_ch_tgl[n];
               end
            end
         end
         if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   // Transmit FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_phase  <= '0;
         r_psc    <= '0;
         r_tx_sh  <= '0;
         r_tx_bit <= '0;
         r_tx_clk <= 1'b1;
         r_tx_dat <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_phase  <= w_phase_nxt;
         r_psc    <= w_psc_nxt;
         r_tx_sh  <= w_tx_sh_nxt;
         r_tx_bit <= w_tx_bit_nxt;
         r_tx_clk <= w_tx_clk_nxt;
         r_tx_dat <= w_tx_dat_nxt;
      end
   end

   // Transmit FSM next state: data changes only when entering LOW
   always_comb begin
      w_state_nxt  = r_state;
      w_phase_nxt  = r_phase;
      w_psc_nxt    = r_psc;
      w_tx_sh_nxt  = r_tx_sh;
      w_tx_bit_nxt = r_tx_bit;
      w_tx_clk_nxt = r_tx_clk;
      w_tx_dat_nxt = r_tx_dat;
      w_hold_take  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx_clk_nxt = 1'b1;
            if (r_hold_vld) begin
               w_hold_take  = 1'b1;
               w_psc_nxt    = i_prescaler;
               w_phase_nxt  = '0;
               w_tx_bit_nxt = '0;
               w_tx_dat_nxt = r_hold[FRAME_W-1];
               w_tx_sh_nxt  = {r_hold[FRAME_W-2:0], 1'b0};
               w_tx_clk_nxt = 1'b0;
               w_state_nxt  = S_LOW;
            end
         end
         S_LOW: begin
            if (r_phase == r_psc) begin
               w_phase_nxt  = '0;
               w_tx_clk_nxt = 1'b1;
               w_state_nxt  = S_HIGH;
            end else begin
               w_phase_nxt = r_phase + 8'd1;
            end
         end
         S_HIGH: begin
            if (r_phase == r_psc) begin
               w_phase_nxt = '0;
               if (r_tx_bit == CNT_W'(FRAME_W - 1)) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_tx_bit_nxt = r_tx_bit + CNT_W'(1);
                  w_tx_dat_nxt = r_tx_sh[FRAME_W-1];
                  w_tx_sh_nxt  = {r_tx_sh[FRAME_W-2:0], 1'b0};
                  w_tx_clk_nxt = 1'b0;
                  w_state_nxt  = S_LOW;
               end
            end else begin
               w_phase_nxt = r_phase + 8'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_tx_clk              = r_tx_clk;
   assign o_tx_data             = r_tx_dat;
   assign o_debug_incoming_data = r_ch_data;
   assign o_debug_incoming_tgl  = r_ch_tgl;
   assign o_node_addr           = r_node_addr;
   assign o_enumerated          = r_enumerated;

endmodule
